// File: rtl/ber_checker.sv
// ---------------------------------------------------------------------------
// ber_checker
//
// Bit-error-rate checker at the receive end of the TX-filter chain. The slicer
// hard decision is compared against a delayed copy of the transmit PRBS9
// reference. The block first sweeps every tap of the reference delay line,
// counting mismatches over a fixed window per tap. It then locks onto the tap
// with the fewest errors (lowest tap on a tie) and accumulates total-bit and
// error counts for readout.
//
// Optional feature (macro BER_EARLY_LOCK_EN):
//   defined   - the first window that closes with zero errors locks at once.
//   undefined - all REF_LEN taps are always swept before locking.
//
// Parameters:
//   REF_LEN  reference delay-line depth = number of candidate taps
//   WINDOW   enabled symbols observed per candidate tap
//   CNT_W    width of the bit/error counters
//
// Ports:
//   clock         system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_enable      symbol strobe; all state advances only while high
//   i_prbs        TX PRBS9 reference bit
//   i_slicer      received hard-decision bit
//   i_resync      synchronous restart of the search (wins over i_enable)
//   o_locked      high once the best tap has been chosen
//   o_best_delay  chosen tap index (reads 0 while searching)
//   o_bit_count   bits compared since lock (saturating)
//   o_err_count   mismatches since lock (freezes with o_bit_count)
// ---------------------------------------------------------------------------
module ber_checker #(
  parameter int unsigned REF_LEN = 511,
  parameter int unsigned WINDOW  = 511,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_prbs,
  input  logic             i_slicer,
  input  logic             i_resync,
  output logic             o_locked,
  output logic [8:0]       o_best_delay,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ERR_W = $clog2(WINDOW + 1);
  localparam logic [8:0]       LAST_TAP = 9'(REF_LEN - 1);
  localparam logic [WIN_W-1:0] LAST_W   = WIN_W'(WINDOW - 1);

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t             state;
  logic [REF_LEN-1:0] ref_sr;
  logic [8:0]         tap;
  logic [8:0]         best_delay;
  logic [WIN_W-1:0]   win_cnt;
  logic [ERR_W-1:0]   win_err;
  logic [ERR_W-1:0]   best_err;

  logic [REF_LEN-1:0] tap_sel;
  logic [REF_LEN-1:0] best_sel;
  logic               search_mm;
  logic               lock_mm;
  logic [ERR_W-1:0]   final_err;
  logic               win_close;
  logic               new_best;
  logic               early_hit;

  // Tap selection uses the pre-shift delay line, so tap k holds the reference
  // bit from k+1 enables before the one being compared.
  always_comb begin
    tap_sel   = ref_sr >> tap;
    best_sel  = ref_sr >> best_delay;
    search_mm = i_slicer ^ tap_sel[0];
    lock_mm   = i_slicer ^ best_sel[0];
    final_err = win_err + ERR_W'(search_mm);
    win_close = (win_cnt == LAST_W);
    new_best  = (final_err < best_err);
`ifdef BER_EARLY_LOCK_EN
    early_hit = (final_err == '0);
`else
    early_hit = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_SEARCH;
      ref_sr       <= '0;
      tap          <= '0;
      best_delay   <= '0;
      win_cnt      <= '0;
      win_err      <= '0;
      best_err     <= '1;
      o_locked     <= 1'b0;
      o_best_delay <= '0;
      o_bit_count  <= '0;
      o_err_count  <= '0;
    end else if (i_resync) begin
      // Restart the sweep; the delay line keeps its contents and the sample
      // presented alongside the request is dropped.
      state        <= ST_SEARCH;
      tap          <= '0;
      best_delay   <= '0;
      win_cnt      <= '0;
      win_err      <= '0;
      best_err     <= '1;
      o_locked     <= 1'b0;
      o_best_delay <= '0;
      o_bit_count  <= '0;
      o_err_count  <= '0;
    end else if (i_enable) begin
      ref_sr <= {ref_sr[REF_LEN-2:0], i_prbs};
      case (state)
        ST_SEARCH: begin
          if (win_close) begin
            win_cnt <= '0;
            win_err <= '0;
            if (early_hit) begin
              best_err     <= final_err;
              best_delay   <= tap;
              o_best_delay <= tap;
              o_locked     <= 1'b1;
              state        <= ST_LOCKED;
            end else begin
              if (new_best) begin
                best_err   <= final_err;
                best_delay <= tap;
              end
              if (tap == LAST_TAP) begin
                // The last window's own result must reach the output in the
                // same edge that raises o_locked.
                o_best_delay <= new_best ? tap : best_delay;
                o_locked     <= 1'b1;
                state        <= ST_LOCKED;
              end else begin
                tap <= tap + 9'd1;
              end
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= final_err;
          end
        end
        ST_LOCKED: begin
          // Both counters stop together once the bit count saturates.
          if (o_bit_count != '1) begin
            o_bit_count <= o_bit_count + 1'b1;
            o_err_count <= o_err_count + CNT_W'(lock_mm);
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
module tb_ber_checker;

  localparam int unsigned REF_LEN    = 32;
  localparam int unsigned WINDOW     = 64;
  localparam int unsigned CNT_W      = 14;
  localparam int unsigned SEARCH_LEN = REF_LEN * WINDOW;
  localparam longint      CNT_MAX    = (longint'(1) << CNT_W) - 1;

  logic             clock    = 1'b0;
  logic             i_reset  = 1'b0;
  logic             i_enable = 1'b0;
  logic             i_prbs   = 1'b0;
  logic             i_slicer = 1'b0;
  logic             i_resync = 1'b0;
  logic             o_locked;
  logic [8:0]       o_best_delay;
  logic [CNT_W-1:0] o_bit_count;
  logic [CNT_W-1:0] o_err_count;

  ber_checker #(
    .REF_LEN(REF_LEN),
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_prbs      (i_prbs),
    .i_slicer    (i_slicer),
    .i_resync    (i_resync),
    .o_locked    (o_locked),
    .o_best_delay(o_best_delay),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ------------------------------------------------------------------
  // Reference model: keeps the enabled reference history as a queue and
  // scores every candidate tap over its window, picking the argmin.
  // ------------------------------------------------------------------
  bit     mh[$];
  int     tap_err[REF_LEN];
  int     m_n;
  bit     m_locked;
  int     m_best;
  longint m_bits;
  longint m_errs;

  function automatic bit ref_bit(int k);
    if (mh.size() > k) return mh[mh.size()-1-k];
    return 1'b0;
  endfunction

  task automatic model_clear(bit clear_hist);
    if (clear_hist) mh.delete();
    for (int k = 0; k < REF_LEN; k++) tap_err[k] = 0;
    m_n = 0; m_locked = 0; m_best = 0; m_bits = 0; m_errs = 0;
  endtask

  task automatic model_step(bit en, bit p, bit s, bit rs);
    int d;
    int b;
    if (rs) begin
      model_clear(1'b0);
      return;
    end
    if (!en) return;
    if (!m_locked) begin
      d = m_n / WINDOW;
      tap_err[d] += (s != ref_bit(d)) ? 1 : 0;
      m_n++;
      if (m_n % WINDOW == 0) begin
`ifdef BER_EARLY_LOCK_EN
        if (tap_err[d] == 0) begin m_locked = 1; m_best = d; end
`endif
        if (!m_locked && d == REF_LEN - 1) begin
          b = 0;
          for (int k = 1; k < REF_LEN; k++) if (tap_err[k] < tap_err[b]) b = k;
          m_best = b; m_locked = 1;
        end
      end
    end else if (m_bits != CNT_MAX) begin
      m_bits++;
      m_errs += (s != ref_bit(m_best)) ? 1 : 0;
    end
    mh.push_back(p);
    if (mh.size() > REF_LEN + 4) void'(mh.pop_front());
  endtask

  task automatic check_state(string name);
    total++;
    if (o_locked === m_locked && o_best_delay === 9'(m_best) &&
        o_bit_count === CNT_W'(m_bits) && o_err_count === CNT_W'(m_errs))
      passed++;
    else
      $display("FAIL %s: got locked=%0b best=%0d bits=%0d errs=%0d, expected locked=%0b best=%0d bits=%0d errs=%0d",
               name, o_locked, o_best_delay, o_bit_count, o_err_count,
               m_locked, m_best, m_bits, m_errs);
  endtask

  // ------------------------------------------------------------------
  // Stimulus: TX PRBS9 generator and a channel that delays it.
  // ------------------------------------------------------------------
  bit         tx[$];
  int         delay_d   = 7;
  bit         zero_mode = 0;
  logic [8:0] lfsr      = 9'h1FF;

  function automatic bit prbs_next();
    bit b;
    b = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], b};
    return b;
  endfunction

  task automatic step(bit en, bit flip, bit rs);
    bit p;
    bit s;
    if (en) begin
      p = zero_mode ? 1'b0 : prbs_next();
      tx.push_back(p);
      if (tx.size() > 64) void'(tx.pop_front());
      s = (tx.size() > delay_d) ? tx[tx.size()-1-delay_d] : 1'b0;
      s ^= flip;
    end else begin
      p = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
    end
    i_enable = en; i_prbs = p; i_slicer = s; i_resync = rs;
    @(posedge clock);
    model_step(en, p, s, rs);
    #1;
    check_state("cycle");
  endtask

  // mode 0: enable every 4th clock; otherwise percent enable density.
  task automatic run_until_lock(string name, int mode, output int ens);
    bit en;
    ens = 0;
    for (int c = 0; c < 4 * SEARCH_LEN + 100; c++) begin
      en = (mode == 0) ? (c % 4 == 3) : ($urandom_range(0, 99) < mode);
      step(en, 1'b0, 1'b0);
      if (en) ens++;
      if (o_locked) break;
    end
    check({name, " locked"}, o_locked, 1);
  endtask

  function automatic int exp_lock(int tap);
`ifdef BER_EARLY_LOCK_EN
    return (tap + 1) * WINDOW;
`else
    return SEARCH_LEN;
`endif
  endfunction

  task automatic async_reset_check(string name);
    #2 i_reset = 1'b0;
    model_clear(1'b1);
    #1;
    check({name, " locked"}, o_locked, 0);
    check({name, " best"}, o_best_delay, 0);
    check({name, " bits"}, o_bit_count, 0);
    check({name, " errs"}, o_err_count, 0);
    @(posedge clock);
    #3 i_reset = 1'b1;
  endtask

  typedef struct {
    bit en;
    bit flip;
    bit rs;
    bit exp_locked;
    int dbits;
    int derrs;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     ens;
    longint base_b;
    longint base_e;
    int     nsat;

    tbl[0] = '{1, 0, 0, 1, 1, 0};
    tbl[1] = '{0, 1, 0, 1, 1, 0};
    tbl[2] = '{1, 1, 0, 1, 2, 1};
    tbl[3] = '{1, 1, 0, 1, 3, 2};
    tbl[4] = '{1, 0, 0, 1, 4, 2};
    tbl[5] = '{0, 0, 0, 1, 4, 2};
    tbl[6] = '{1, 1, 1, 0, 0, 0};

    model_clear(1'b1);
    repeat (3) @(posedge clock);
    #1;
    check_state("reset");
    check("reset locked", o_locked, 0);
    #2 i_reset = 1'b1;

    // Pure delay of 7 enables, strobe every 4th clock.
    delay_d = 7;
    run_until_lock("pure", 0, ens);
    check("pure best", o_best_delay, 6);
    check("pure lock enables", ens, exp_lock(6));
    repeat (200) step(1'b1, 1'b0, 1'b0);
    check("pure bits", o_bit_count, 200);
    check("pure errs", o_err_count, 0);

    // Short hand-built sequence: gating, forced errors, resync with enable.
    base_b = m_bits;
    base_e = m_errs;
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].flip, tbl[i].rs);
      check($sformatf("tbl%0d locked", i), o_locked, tbl[i].exp_locked);
      check($sformatf("tbl%0d bits", i), o_bit_count,
            tbl[i].exp_locked ? base_b + tbl[i].dbits : 0);
      check($sformatf("tbl%0d errs", i), o_err_count,
            tbl[i].exp_locked ? base_e + tbl[i].derrs : 0);
    end

    // Relock after the path delay changes to 20.
    delay_d = 20;
    run_until_lock("relock", 70, ens);
    check("relock best", o_best_delay, 19);
    check("relock enables", ens, exp_lock(19));

    // Error injection: every 100th bit inverted over 10000 enables.
    for (int i = 0; i < 10000; i++) step(1'b1, (i % 100) == 99, 1'b0);
    check("inject bits", o_bit_count, 10000);
    check("inject errs", o_err_count, 100);

    // Enable held low: counters and delay line hold.
    repeat (1000) step(1'b0, 1'b0, 1'b0);
    check("gate bits", o_bit_count, 10000);
    check("gate errs", o_err_count, 100);
    repeat (50) step(1'b1, 1'b0, 1'b0);
    check("post-gate bits", o_bit_count, 10050);
    check("post-gate errs", o_err_count, 100);

    // Saturation: run past all-ones, counters must freeze together.
    nsat = int'(CNT_MAX - m_bits) + 40;
    for (int i = 0; i < nsat; i++) step(1'b1, $urandom_range(0, 9) == 0, 1'b0);
    check("sat bits", o_bit_count, CNT_MAX);
    check("sat errs", o_err_count, m_errs);

    // Tie-break: all-zero reference and slicer, every window is error-free.
    zero_mode = 1;
    repeat (40) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    run_until_lock("tie", 100, ens);
    check("tie best", o_best_delay, 0);
    check("tie enables", ens, exp_lock(0));
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check("tie bits", o_bit_count, 10);

    // Asynchronous reset while counting.
    async_reset_check("arst count");

    // Asynchronous reset mid-search at tap 3, then a full restart.
    zero_mode = 0;
    delay_d   = 7;
    repeat (3 * WINDOW + 5) step(1'b1, 1'b0, 1'b0);
    async_reset_check("arst search");
    run_until_lock("restart", 90, ens);
    check("restart best", o_best_delay, 6);
    check("restart enables", ens, exp_lock(6));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
